// File: rtl/recovery_pkg.sv
// recovery_pkg: FSM state encoding and default parameters shared by the recovery controller
package recovery_pkg;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ACQUIRE = 3'd1,
      TRACK   = 3'd2,
      LOCKED  = 3'd3,
      LOST    = 3'd4
   } state_t;
   localparam int DEF_CLK_LEN    = 32;
   localparam int DEF_ACQ_EDGES  = 16;
   localparam int DEF_LOCK_EDGES = 16;
   localparam int DEF_MISS_LIMIT = 4;
   localparam int DEF_TOL_SHIFT  = 3;
   localparam int DEF_WD_SHIFT   = 5;
endpackage

// File: rtl/interval_classify.sv
// interval_classify: sorts an edge interval into hit / miss / long against period +- (period >> TOL_SHIFT)
module interval_classify #(
   parameter int CLK_LEN   = 32,
   parameter int TOL_SHIFT = 3
) (
   input  logic [CLK_LEN-1:0] interval,
   input  logic [CLK_LEN-1:0] period,
   output logic               hit,
   output logic               miss,
   output logic               long_run
);
   logic [CLK_LEN:0] per_x, iv_x, tol, lo, hi;
   // one extra bit keeps period-tol from underflowing and period+tol from wrapping
   always_comb begin
      per_x    = {1'b0, period};
      iv_x     = {1'b0, interval};
      tol      = per_x >> TOL_SHIFT;
      lo       = per_x - tol;
      hi       = per_x + tol;
      miss     = iv_x < lo;
      long_run = iv_x > hi;
      hit      = !miss && !long_run;
   end
endmodule

// File: rtl/recovery_ctrl.sv
// recovery_ctrl: acquires a bit-period estimate from edge intervals, tracks lock, and restarts on loss
module recovery_ctrl
   import recovery_pkg::*;
#(
   parameter int CLK_LEN    = DEF_CLK_LEN,
   parameter int ACQ_EDGES  = DEF_ACQ_EDGES,
   parameter int LOCK_EDGES = DEF_LOCK_EDGES,
   parameter int MISS_LIMIT = DEF_MISS_LIMIT,
   parameter int TOL_SHIFT  = DEF_TOL_SHIFT,
   parameter int WD_SHIFT   = DEF_WD_SHIFT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               edge_stb,
   input  logic [CLK_LEN-1:0] interval,
   output logic [CLK_LEN-1:0] period,
   output logic               period_valid,
   output logic               locked,
   output logic               restart,
   output state_t             state
);
   localparam int AW = $clog2(ACQ_EDGES + 1);
   localparam int HW = $clog2(LOCK_EDGES + 1);
   localparam int MW = $clog2(MISS_LIMIT + 1);
   localparam int WW = CLK_LEN + WD_SHIFT;

   state_t             nxt;
   logic [CLK_LEN-1:0] min_q, min_new, wd, wd_lim;
   logic [WW-1:0]      wd_wide;
   logic [AW-1:0]      acq_cnt, acq_inc;
   logic [HW-1:0]      hit_cnt, hit_inc;
   logic [MW-1:0]      miss_cnt, miss_inc;
   logic               first, hit, miss, long_run, tracking, acq_init, acq_take, trk_edge;

   interval_classify #(.CLK_LEN(CLK_LEN), .TOL_SHIFT(TOL_SHIFT)) u_classify (
      .interval (interval),
      .period   (period),
      .hit      (hit),
      .miss     (miss),
      .long_run (long_run)
   );

   // watchdog limit is period << WD_SHIFT, pinned to all-ones when the shift overflows
   always_comb begin
      wd_wide = {{WD_SHIFT{1'b0}}, period} << WD_SHIFT;
      wd_lim  = (|wd_wide[WW-1:CLK_LEN]) ? '1 : wd_wide[CLK_LEN-1:0];
   end

   // next-state decode: enable low wins, then a miss-driven loss beats a lock, and an edge beats expiry
   always_comb begin
      nxt      = state;
      tracking = (state == TRACK) || (state == LOCKED);
      acq_inc  = acq_cnt + 1'b1;
      hit_inc  = (hit_cnt == HW'(LOCK_EDGES)) ? hit_cnt : hit_cnt + 1'b1;
      miss_inc = miss_cnt + 1'b1;
      min_new  = (interval < min_q) ? interval : min_q;
      acq_init = enable && (state == IDLE || state == LOST);
      acq_take = enable && state == ACQUIRE && edge_stb && !first && interval >= CLK_LEN'(2);
      trk_edge = enable && tracking && edge_stb;
      if (!enable) nxt = IDLE;
      else if (acq_init) nxt = ACQUIRE;
      else if (acq_take && acq_inc == AW'(ACQ_EDGES)) nxt = TRACK;
      else if (trk_edge && miss && miss_inc == MW'(MISS_LIMIT)) nxt = LOST;
      else if (trk_edge && state == TRACK && hit && hit_inc == HW'(LOCK_EDGES)) nxt = LOCKED;
      else if (tracking && !edge_stb && wd >= wd_lim) nxt = LOST;
      else if (state > LOST) nxt = IDLE;
   end

   // state plus status flags, registered on the same edge as the transition that drives them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         restart      <= 1'b0;
      end else begin
         state        <= nxt;
         period_valid <= (nxt == TRACK) || (nxt == LOCKED);
         locked       <= nxt == LOCKED;
         restart      <= acq_init;
      end
   end

   // acquisition min/count and tracking hit/miss counters; period only changes when acquisition completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period   <= '0;
         min_q    <= '1;
         acq_cnt  <= '0;
         first    <= 1'b1;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (acq_init) begin
            min_q   <= '1;
            acq_cnt <= '0;
            first   <= 1'b1;
         end else if (enable && state == ACQUIRE && edge_stb) begin
            first <= 1'b0;
            if (acq_take) begin
               min_q   <= min_new;
               acq_cnt <= acq_inc;
            end
         end
         if (acq_take && nxt == TRACK) begin
            period   <= min_new;
            hit_cnt  <= '0;
            miss_cnt <= '0;
         end else if (trk_edge) begin
            hit_cnt  <= hit ? hit_inc : hit_cnt;
            miss_cnt <= hit ? '0 : (long_run ? miss_cnt : miss_inc);
         end
      end
   end

   // watchdog: cycles since the last edge strobe, saturating at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wd <= '0;
      else wd <= edge_stb ? '0 : ((&wd) ? wd : wd + 1'b1);
   end
endmodule

// File: tb/tb_recovery_ctrl.sv
// tb_recovery_ctrl: directed and randomized scoreboard bench for recovery_ctrl against a behavioural model
module tb_recovery_ctrl;
   localparam int CL = 32, ACQ = 16, LOCK = 16, MISSL = 4, TS = 3, WS = 5;
   localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;
   localparam int M_IDLE = 0, M_ACQ = 1, M_TRACK = 2, M_LOCKED = 3, M_LOST = 4;

   typedef struct packed {
      logic [2:0]    st;
      logic [CL-1:0] per;
      logic          pv;
      logic          lk;
      logic          rs;
   } obs_t;

   logic clk = 1'b0, rst_n = 1'b1, enable = 1'b0, edge_stb = 1'b0;
   logic [CL-1:0] interval = '0, period;
   logic period_valid, locked, restart;
   logic [2:0] state;

   int checks = 0, errors = 0;
   obs_t sb[$];
   obs_t mexp, mgot;

   int m_mode = M_IDLE, m_acnt = 0, m_hits = 0, m_miss = 0;
   longint m_per = 0, m_min = MAXV, m_since = 0;
   bit m_pv = 0, m_lk = 0, m_rs = 0, m_first = 1;

   recovery_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .edge_stb     (edge_stb),
      .interval     (interval),
      .period       (period),
      .period_valid (period_valid),
      .locked       (locked),
      .restart      (restart),
      .state        (state)
   );

   always #5 clk = ~clk;

   function automatic obs_t model_out();
      return {3'(m_mode), CL'(m_per), m_pv, m_lk, m_rs};
   endfunction

   // one clock of the behavioural model, written from the rules rather than the RTL structure
   task automatic model_step();
      longint iv, tol, lim;
      bit ed;
      iv  = longint'(interval);
      ed  = edge_stb;
      tol = m_per / (1 << TS);
      lim = m_per * (1 << WS);
      if (lim > MAXV) lim = MAXV;
      m_rs = 0;
      if (!enable) begin
         m_mode = M_IDLE; m_pv = 0; m_lk = 0;
      end else if (m_mode == M_IDLE || m_mode == M_LOST) begin
         m_mode = M_ACQ; m_rs = 1; m_pv = 0; m_lk = 0; m_first = 1; m_acnt = 0; m_min = MAXV;
      end else if (m_mode == M_ACQ) begin
         if (ed && m_first) m_first = 0;
         else if (ed && iv >= 2) begin
            m_acnt++;
            if (iv < m_min) m_min = iv;
            if (m_acnt == ACQ) begin
               m_per = m_min; m_pv = 1; m_hits = 0; m_miss = 0; m_mode = M_TRACK;
            end
         end
      end else if (ed) begin
         if (iv >= m_per - tol && iv <= m_per + tol) begin
            if (m_hits < LOCK) m_hits++;
            m_miss = 0;
         end else if (iv < m_per - tol) m_miss++;
         if (m_miss == MISSL) begin
            m_mode = M_LOST; m_pv = 0; m_lk = 0;
         end else if (m_mode == M_TRACK && m_hits == LOCK) begin
            m_mode = M_LOCKED; m_lk = 1;
         end
      end else if (m_since >= lim) begin
         m_mode = M_LOST; m_pv = 0; m_lk = 0;
      end
      m_since = ed ? 0 : ((m_since < MAXV) ? m_since + 1 : MAXV);
   endtask

   // stimulus side of the scoreboard: every clock (or reset) pushes the expected outputs
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb.delete();
         m_mode = M_IDLE; m_per = 0; m_pv = 0; m_lk = 0; m_rs = 0;
         m_first = 1; m_acnt = 0; m_hits = 0; m_miss = 0; m_min = MAXV; m_since = 0;
      end else model_step();
      sb.push_back(model_out());
   end

   // monitor: compares DUT outputs mid-cycle against the oldest expectation
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mexp = sb.pop_front();
         mgot = {state, period, period_valid, locked, restart};
         checks++;
         if (mgot !== mexp) begin
            errors++;
            $display("FAIL scoreboard t=%0t: got st=%0d per=%0d pv=%0b lk=%0b rs=%0b, expected st=%0d per=%0d pv=%0b lk=%0b rs=%0b",
                     $time, mgot.st, mgot.per, mgot.pv, mgot.lk, mgot.rs, mexp.st, mexp.per, mexp.pv, mexp.lk, mexp.rs);
         end
      end
   end

   task automatic chk(string name, longint got, longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // strobe an edge after iv cycles (at least one), carrying interval=iv
   task automatic send(int iv);
      edge_stb = 1'b0;
      repeat ((iv < 1 ? 1 : iv) - 1) tick();
      edge_stb = 1'b1;
      interval = CL'(iv);
      tick();
      edge_stb = 1'b0;
      interval = $urandom;
   endtask

   task automatic acquire(int p);
      send(p + 1);
      repeat (ACQ) send(p);
   endtask

   initial begin
      int base;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_state", state, M_IDLE);
      chk("reset_period", period, 0);
      chk("reset_pv", period_valid, 0);
      chk("reset_locked", locked, 0);
      chk("reset_restart", restart, 0);
      repeat (3) tick();
      rst_n  = 1'b1;
      enable = 1'b1;
      tick();
      chk("first_restart", restart, 1);
      chk("first_acquire", state, M_ACQ);
      // acquisition to period 12 with a discarded first edge, an ignored short edge and a 24 outlier
      send(13);
      send(1);
      for (int i = 0; i < 15; i++) send(i == 2 ? 24 : 12);
      chk("pv_before_16th", period_valid, 0);
      send(12);
      chk("acq_state", state, M_TRACK);
      chk("acq_period", period, 12);
      chk("acq_pv", period_valid, 1);
      // lock on exactly the 16th hit, with multi-bit runs interleaved
      for (int i = 0; i < LOCK; i++) begin
         if ($urandom_range(0, 2) == 0) send(36);
         if (i == LOCK - 1) chk("unlocked_before_16th", locked, 0);
         send(11 + $urandom_range(0, 2));
      end
      chk("locked_16th", locked, 1);
      chk("locked_state", state, M_LOCKED);
      // four short intervals force one LOST cycle
      repeat (MISSL - 1) send(6);
      chk("still_locked_3miss", state, M_LOCKED);
      send(6);
      chk("lost_state", state, M_LOST);
      chk("lost_locked", locked, 0);
      tick();
      chk("reacq_state", state, M_ACQ);
      chk("reacq_restart", restart, 1);
      tick();
      chk("restart_one_cycle", restart, 0);
      // enable low mid-TRACK keeps the period
      acquire(12);
      send(12);
      chk("track_before_disable", state, M_TRACK);
      enable = 1'b0;
      tick();
      chk("disable_idle", state, M_IDLE);
      chk("disable_period", period, 12);
      chk("disable_pv", period_valid, 0);
      chk("disable_restart", restart, 0);
      enable = 1'b1;
      // watchdog expiry at period<<5 = 384
      acquire(12);
      repeat (LOCK) send(12);
      chk("wd_locked", state, M_LOCKED);
      repeat (384) tick();
      chk("wd_not_yet", state, M_LOCKED);
      tick();
      chk("wd_lost", state, M_LOST);
      tick();
      // an edge on the exact expiry cycle is processed instead
      acquire(12);
      repeat (LOCK) send(12);
      send(385);
      chk("edge_at_expiry", state, M_LOCKED);
      send(12);
      chk("locked_after_expiry_edge", state, M_LOCKED);
      // asynchronous reset mid-ACQUIRE
      enable = 1'b0;
      tick();
      enable = 1'b1;
      tick();
      send(13);
      send(12);
      chk("pre_reset_acq", state, M_ACQ);
      rst_n = 1'b0;
      #1;
      chk("async_state", state, M_IDLE);
      chk("async_period", period, 0);
      chk("async_pv", period_valid, 0);
      chk("async_restart", restart, 0);
      tick();
      tick();
      rst_n = 1'b1;
      // randomized phase: jittered edges, outliers, long silences and enable drops
      base = 12;
      for (int n = 0; n < 600; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (n % 40 == 0) base = int'($urandom_range(4, 20));
         if (r < 2) begin
            enable = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            enable = 1'b1;
         end
         if (r < 4) send(int'($urandom_range(100, 700)));
         else if (r < 10) send(int'($urandom_range(0, 3 * base)));
         else send(base - 1 + int'($urandom_range(0, 2)));
      end
      tick();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/recovery_ctrl.md
RECOVERY_CTRL -- requirements
Module: recovery_ctrl

Interface
REQ-001 Parameter CLK_LEN, default 32, sets the width of interval, period and watchdog.
REQ-002 Parameter ACQ_EDGES, default 16, sets the number of valid edges sampled per acquisition.
REQ-003 Parameter LOCK_EDGES, default 16, sets the number of in-tolerance edges required to declare lock.
REQ-004 Parameter MISS_LIMIT, default 4, sets the number of consecutive short intervals that forces re-acquisition.
REQ-005 Parameter TOL_SHIFT, default 3, sets the tolerance as tol = period >> TOL_SHIFT.
REQ-006 Parameter WD_SHIFT, default 5, sets the watchdog limit as period << WD_SHIFT cycles.
REQ-007 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-008 Port rst_n, input, 1: asynchronous active-low reset.
REQ-009 Port enable, input, 1: run request; 0 forces IDLE.
REQ-010 Port edge_stb, input, 1: one-cycle strobe marking a detected signal edge.
REQ-011 Port interval, input, CLK_LEN: cycles since the previous edge, valid only while edge_stb=1.
REQ-012 Port period, output, CLK_LEN: the current bit-period estimate in clk cycles.
REQ-013 Port period_valid, output, 1: period holds an acquired value.
REQ-014 Port locked, output, 1: tracking is stable.
REQ-015 Port restart, output, 1: one-cycle pulse that tells the recovery datapath to clear its counters.
REQ-016 Port state, output, 3: the current FSM state encoding.

Function
REQ-017 The FSM SHALL have states IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3 and LOST=4.
REQ-018 In IDLE, when enable=1, the FSM SHALL pulse restart, clear the min register to all-ones and the edge count to 0, and enter ACQUIRE on the next cycle.
REQ-019 In ACQUIRE, the first edge_stb SHALL be discarded, and any edge with interval<2 SHALL be ignored.
REQ-020 In ACQUIRE, each other edge SHALL increment the edge count and set min = the lesser of min and interval.
REQ-021 When the edge count reaches ACQ_EDGES, the FSM SHALL load period=min, set period_valid=1, clear the hit and miss counters, and enter TRACK in the same cycle as that edge.
REQ-022 In TRACK and LOCKED, an edge with |interval-period| <= tol SHALL be a hit: it increments the saturating hit counter and clears the miss counter.
REQ-023 An edge with interval < period-tol SHALL be a miss: it increments the miss counter and leaves the hit counter unchanged.
REQ-024 An edge with interval > period+tol (a multi-bit run) SHALL change neither the hit nor the miss counter.
REQ-025 In TRACK, when the hit counter reaches LOCK_EDGES, the FSM SHALL enter LOCKED and set locked=1.
REQ-026 In TRACK or LOCKED, when the miss counter reaches MISS_LIMIT, the FSM SHALL enter LOST.
REQ-027 The watchdog SHALL count cycles since the last edge_stb, saturate at all-ones, and clear on every edge_stb.
REQ-028 In TRACK or LOCKED, a watchdog value >= period<<WD_SHIFT SHALL cause entry to LOST.
REQ-029 The shifted watchdog limit SHALL saturate to all-ones on overflow.
REQ-030 LOST SHALL last exactly one cycle: it clears locked and period_valid, pulses restart, reinitialises the acquisition registers and enters ACQUIRE.
REQ-031 When edge_stb coincides with watchdog expiry in the same cycle, the edge SHALL be processed and the expiry ignored.
REQ-032 When a miss reaching MISS_LIMIT coincides with the hit counter reaching LOCK_EDGES, LOST SHALL win.
REQ-033 A synchronous enable=0 in any state SHALL force IDLE on the next edge, clear locked and period_valid, keep period, and not pulse restart.
REQ-034 tol and the comparisons SHALL use CLK_LEN+1-bit arithmetic, so period-tol never underflows and period+tol never wraps.
REQ-035 The locked and period_valid outputs SHALL be registered with zero added latency relative to the state transition that sets them.

Reset
REQ-036 Asserting rst_n=0 SHALL asynchronously force state=IDLE, period=0, period_valid=0, locked=0, restart=0, and clear all counters.
REQ-037 After rst_n deassertion with enable held at 1, the first restart pulse SHALL occur on the first clk edge.

Structure
REQ-038 The state encoding and the default parameter constants SHALL live in the shared package recovery_pkg.
REQ-039 The tolerance/window classifier (hit, miss, long from interval, period and TOL_SHIFT) SHALL be one combinational sub-module named interval_classify.

Verification
REQ-040 Directed test: enable=1 with edges of intervals 13,12,12,24,12,... -> period=12 and period_valid=1 on the 16th counted edge; state=TRACK.
REQ-041 Directed test: after acquisition at period=12 (tol=1), 16 intervals of 11..13 mixed with 36 -> locked=1 exactly on the 16th hit.
REQ-042 Directed test: from LOCKED, 4 consecutive intervals of 6 -> LOST for 1 cycle, one restart pulse, then ACQUIRE with locked=0.
REQ-043 Directed test: from LOCKED at period=12, no edges for 384 cycles -> LOST on the cycle the watchdog reaches 384.
REQ-044 Directed test: an edge_stb arriving on the exact watchdog-expiry cycle -> state stays LOCKED.
REQ-045 Directed test: rst_n pulsed low mid-ACQUIRE -> all outputs 0 immediately; enable=0 mid-TRACK -> IDLE next cycle with period retained.
